// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared widths, latency limits and FSM encoding for the data memory initiator.
package mem_access_unit_pkg;
    localparam int DATA_W_DEF       = 16;
    localparam int ADDR_W_DEF       = 5;
    localparam int MAX_READ_LATENCY = 7;
    localparam int CNT_W            = 3;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2,
        RSP     = 2'd3
    } state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: core request/response and data memory signals of the access unit.
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_d_in;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_d_out;
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_d_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_d_in, mem_wr
    );
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_d_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_d_in, mem_wr
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator for the data memory port.
// Define MEM_WRITE_VERIFY_EN to read back every store and flag a mismatch on rsp_err.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             accept, capture;

    assign bus.req_ready = rst_n && state == IDLE;
    assign bus.mem_wr    = state == WR;
    assign bus.rsp_valid = state == RSP;
    assign accept        = bus.req_valid && bus.req_ready;
    assign capture       = state == RD_WAIT && cnt == '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (bus.req_we ? WR : RD_WAIT) : IDLE;
`ifdef MEM_WRITE_VERIFY_EN
            WR:      state_nx = RD_WAIT;
`else
            WR:      state_nx = RSP;
`endif
            RD_WAIT: state_nx = capture ? RSP : RD_WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // Counter is armed on accept and again in WR so a verify read-back waits the full latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.mem_addr  <= '0;
            bus.mem_d_in  <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (accept || bus.mem_wr) ? CNT_W'(READ_LATENCY - 1) :
                     (capture || state != RD_WAIT) ? cnt : cnt - 1'b1;
            if (accept) begin
                bus.mem_addr <= bus.req_addr;
                bus.mem_d_in <= bus.req_wdata;
            end
            if (capture) bus.rsp_rdata <= bus.mem_d_out;
        end
    end

`ifdef MEM_WRITE_VERIFY_EN
    logic is_store;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_store    <= 1'b0;
            bus.rsp_err <= 1'b0;
        end else begin
            if (accept) is_store <= bus.req_we;
            if (capture) bus.rsp_err <= is_store && bus.mem_d_out != bus.mem_d_in;
        end
    end
`else
    assign bus.rsp_err = 1'b0;
`endif
endmodule
